// File: rtl/led_chaser.sv
// LED chaser: N_LEDS-wide rotate/bounce/bar pattern at a programmable rate.
// Ports: clock, rst_n, enable, mode[1:0], speed_div, [brightness], step, LEDout.
// Optional macro LED_CHASER_PWM_EN adds brightness[3:0] and PWM dimming.
module led_chaser #(
  parameter int N_LEDS    = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] speed_div,
`ifdef LED_CHASER_PWM_EN
  input  logic [3:0]           brightness,
`endif
  output logic                 step,
  output logic [N_LEDS-1:0]    LEDout
);

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [N_LEDS-1:0]    PAT_ONE = 1;

  logic [DIV_WIDTH-1:0] cnt, cnt_d;
  logic [N_LEDS-1:0]    pat, pat_d;
  dir_t                 dir, dir_d;
  logic [1:0]           mode_q;
  logic                 armed;
  logic                 step_d;
  logic                 tick;
  logic                 chg;

  // mode_q is not meaningful until the first clock after reset, so the
  // change detector is held off until then (equivalent to loading mode).
  assign chg  = armed && (mode != mode_q);
  assign tick = enable && (cnt >= speed_div);

  always_comb begin
    cnt_d  = cnt;
    pat_d  = pat;
    dir_d  = dir;
    step_d = 1'b0;
    if (chg) begin
      cnt_d = '0;
      pat_d = PAT_ONE;
      dir_d = UP;
    end else if (tick) begin
      cnt_d  = '0;
      step_d = 1'b1;
      unique case (mode_q)
        2'd0: pat_d = {pat[N_LEDS-2:0], pat[N_LEDS-1]};
        2'd1: pat_d = {pat[0], pat[N_LEDS-1:1]};
        2'd2: begin
          if (dir == UP) begin
            if (pat[N_LEDS-1]) begin
              dir_d = DOWN;
              pat_d = pat >> 1;
            end else begin
              pat_d = pat << 1;
            end
          end else begin
            if (pat[0]) begin
              dir_d = UP;
              pat_d = pat << 1;
            end else begin
              pat_d = pat >> 1;
            end
          end
        end
        default: begin
          if (&pat) pat_d = PAT_ONE;
          else      pat_d = {pat[N_LEDS-2:0], 1'b1};
        end
      endcase
    end else if (enable) begin
      cnt_d = cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      pat    <= PAT_ONE;
      dir    <= UP;
      mode_q <= 2'd0;
      armed  <= 1'b0;
      step   <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      pat    <= pat_d;
      dir    <= dir_d;
      mode_q <= mode;
      armed  <= 1'b1;
      step   <= step_d;
    end
  end

`ifdef LED_CHASER_PWM_EN
  logic [3:0]        pwm_cnt, pwm_d;
  logic [N_LEDS-1:0] led_q;

  assign pwm_d = (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;

  // Built from next-state values so LEDout lines up with pat and pwm_cnt
  // in the same cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 4'd0;
      led_q   <= '0;
    end else begin
      pwm_cnt <= pwm_d;
      led_q   <= pat_d & {N_LEDS{pwm_d < brightness}};
    end
  end

  assign LEDout = led_q;
`else
  assign LEDout = pat;
`endif

endmodule

// File: tb/tb_led_chaser.sv
// Directed testbench for led_chaser (N_LEDS=8, DIV_WIDTH=24).
// Checks rotate, bounce, bar fill, pause, mode change, reset and divider.
module tb_led_chaser;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] speed_div = '0;
  logic        step;
  logic [7:0]  LEDout;
`ifdef LED_CHASER_PWM_EN
  logic [3:0]  brightness = 4'd15;
  localparam logic [7:0] RST_LED = 8'h00;
`else
  localparam logic [7:0] RST_LED = 8'h01;
`endif

  int checks = 0;
  int errors = 0;

  led_chaser #(.N_LEDS(8), .DIV_WIDTH(24)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .enable    (enable),
    .mode      (mode),
    .speed_div (speed_div),
`ifdef LED_CHASER_PWM_EN
    .brightness(brightness),
`endif
    .step      (step),
    .LEDout    (LEDout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  logic [7:0] e;
  logic [7:0] bnc [15];
  logic [7:0] bar [9];
  int         on_cnt;

  initial begin
    bnc = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
            8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    bar = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01,
            8'h03};

    #12;
    check("rst_led", 32'(LEDout), 32'(RST_LED));
    check("rst_step", 32'(step), 32'd0);
    @(posedge clock);
    #1;
    rst_n  = 1'b1;
    enable = 1'b1;

    // rotate left, one step per cycle
    for (int k = 1; k <= 9; k++) begin
      cyc(1);
      e = 8'(1 << (k % 8));
      check("rotl_led", 32'(LEDout), 32'(e));
      check("rotl_step", 32'(step), 32'd1);
    end

    // rotate right, div=3
    mode      = 2'd1;
    speed_div = 24'd3;
    cyc(1);
    check("rotr_chg", 32'(LEDout), 32'h01);
    check("rotr_chg_step", 32'(step), 32'd0);
    e = 8'h01;
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        check("rotr_hold", 32'(LEDout), 32'(e));
        check("rotr_hold_step", 32'(step), 32'd0);
      end
      cyc(1);
      e = {e[0], e[7:1]};
      check("rotr_led", 32'(LEDout), 32'(e));
      check("rotr_step", 32'(step), 32'd1);
    end

    // bounce
    mode      = 2'd2;
    speed_div = 24'd0;
    cyc(1);
    check("bnc_chg", 32'(LEDout), 32'h01);
    for (int k = 0; k < 15; k++) begin
      cyc(1);
      check("bnc_led", 32'(LEDout), 32'(bnc[k]));
    end

    // bar fill
    mode = 2'd3;
    cyc(1);
    check("bar_chg", 32'(LEDout), 32'h01);
    for (int k = 0; k < 9; k++) begin
      cyc(1);
      check("bar_led", 32'(LEDout), 32'(bar[k]));
    end

    // pause, then mode change 0 -> 2 at pat=10
    mode = 2'd0;
    cyc(1);
    check("p_chg", 32'(LEDout), 32'h01);
    cyc(2);
    check("p_pre", 32'(LEDout), 32'h04);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check("p_led", 32'(LEDout), 32'h04);
      check("p_step", 32'(step), 32'd0);
    end
    enable = 1'b1;
    cyc(2);
    check("p_resume", 32'(LEDout), 32'h10);
    mode = 2'd2;
    cyc(1);
    check("m_chg_led", 32'(LEDout), 32'h01);
    check("m_chg_step", 32'(step), 32'd0);
    cyc(1);
    check("m_up1", 32'(LEDout), 32'h02);
    cyc(1);
    check("m_up2", 32'(LEDout), 32'h04);

    // async reset mid-count
    mode      = 2'd0;
    speed_div = 24'd5;
    cyc(1);
    check("r_chg", 32'(LEDout), 32'h01);
    cyc(6);
    check("r_step_led", 32'(LEDout), 32'h02);
    check("r_step", 32'(step), 32'd1);
    cyc(3);
    check("r_pre", 32'(LEDout), 32'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_async_led", 32'(LEDout), 32'(RST_LED));
    check("r_async_step", 32'(step), 32'd0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check("r_wait_led", 32'(LEDout), 32'h01);
      check("r_wait_step", 32'(step), 32'd0);
    end
    cyc(1);
    check("r_first_led", 32'(LEDout), 32'h02);
    check("r_first_step", 32'(step), 32'd1);

    // divider lowered mid-count
    speed_div = 24'd100;
    cyc(50);
    check("d_hold", 32'(LEDout), 32'h02);
    check("d_hold_step", 32'(step), 32'd0);
    speed_div = 24'd2;
    cyc(1);
    check("d_wrap_led", 32'(LEDout), 32'h04);
    check("d_wrap_step", 32'(step), 32'd1);

`ifdef LED_CHASER_PWM_EN
    enable     = 1'b0;
    brightness = 4'd5;
    cyc(1);
    on_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      cyc(1);
      if (LEDout != 8'h00) on_cnt++;
    end
    check("pwm_duty", 32'(on_cnt), 32'd5);
`else
    on_cnt = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
